// File: rtl/dircc_avalon_st_generator_if.sv
// Bus bundle for the DiRCC Avalon-ST packet generator.
//   Avalon-ST source: src_data, src_empty, src_startofpacket, src_endofpacket,
//                     src_valid (generator drives), src_ready (sink drives)
//   Avalon-MM slave : ctrl_address, ctrl_read_n, ctrl_write_n, ctrl_writedata
//                     (host drives), ctrl_readdata (generator drives)
// Modports: master = generator side, slave = environment (sink + host) side.
interface dircc_avalon_st_generator_if;
  logic [31:0] src_data;
  logic [1:0]  src_empty;
  logic        src_startofpacket;
  logic        src_endofpacket;
  logic        src_valid;
  logic        src_ready;
  logic [1:0]  ctrl_address;
  logic        ctrl_read_n;
  logic [15:0] ctrl_readdata;
  logic        ctrl_write_n;
  logic [15:0] ctrl_writedata;

  modport master (
    output src_data, src_empty, src_startofpacket, src_endofpacket, src_valid,
    input  src_ready,
    input  ctrl_address, ctrl_read_n, ctrl_write_n, ctrl_writedata,
    output ctrl_readdata
  );

  modport slave (
    input  src_data, src_empty, src_startofpacket, src_endofpacket, src_valid,
    output src_ready,
    output ctrl_address, ctrl_read_n, ctrl_write_n, ctrl_writedata,
    input  ctrl_readdata
  );
endinterface

// File: rtl/dircc_avalon_st_generator.sv
// Avalon-ST packet source with a 16-bit Avalon-MM control slave.
// Emits packets of LEN bytes on a 32-bit, 4-symbol stream; beat k carries
// {SEED, k}. Registers: 0=CTRL (start/stop), 1=LEN, 2=SEED, 3=STATUS.
// Ports:
//   clk_clk     - sole rising-edge clock
//   reset_reset - asynchronous active-high reset
//   bus         - dircc_avalon_st_generator_if.master (stream + control)
// Optional feature: define DIRCC_ST_GEN_REPEAT_EN for repeat mode
// (CTRL bit2, back-to-back packets, SEED +1 per packet).
module dircc_avalon_st_generator #(
  parameter int DEFAULT_LEN = 64,
  parameter int COUNT_W     = 16
) (
  input  logic                               clk_clk,
  input  logic                               reset_reset,
  dircc_avalon_st_generator_if.master        bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [15:0]        len_r, len_s, seed_r, seed_s;
  logic [15:0]        pkt_seed_r, pkt_seed_s, beat_r, beat_s, last_r, last_s;
  logic [1:0]         pkt_empty_r, pkt_empty_s;
  logic [COUNT_W-1:0] count_r, count_s;
  logic               err_r, err_s, stop_r, stop_s;
  logic               valid_r, valid_s, sop_r, sop_s, eop_r, eop_s;
  logic [31:0]        data_r, data_s;
  logic [1:0]         empty_r, empty_s;
  logic               load_s;
  logic [15:0]        load_seed_s;
  logic               wr_s, start_wr_s, stop_wr_s, status_wr_s, rpt_mode_s;
  logic [15:0]        ctrl_rd_s, count_ext_s, rdata_s;

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  // Index of the final beat: ceil(len/4) - 1, valid for len >= 1.
  function automatic logic [15:0] last_idx(input logic [15:0] len);
    return (len - 16'd1) >> 2;
  endfunction

  // Unused byte lanes on the final beat: (4 - len%4) % 4.
  function automatic logic [1:0] tail_empty(input logic [15:0] len);
    return 2'(3'd4 - {1'b0, len[1:0]});
  endfunction

  assign wr_s        = ~bus.ctrl_write_n;
  assign stop_wr_s   = wr_s && (bus.ctrl_address == 2'd0) && bus.ctrl_writedata[1];
  // A write carrying both start and stop is treated as stop only.
  assign start_wr_s  = wr_s && (bus.ctrl_address == 2'd0) && bus.ctrl_writedata[0] && !bus.ctrl_writedata[1];
  assign status_wr_s = wr_s && (bus.ctrl_address == 2'd3);
  assign count_ext_s = 16'(count_r);

`ifdef DIRCC_ST_GEN_REPEAT_EN
  logic rpt_r, rpt_s;
  assign rpt_mode_s = rpt_r;
  assign ctrl_rd_s  = {13'd0, rpt_r, 2'b00};

  // Repeat-mode flag, captured with each start.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rpt_r <= 1'b0;
    end else begin
      rpt_r <= rpt_s;
    end
  end
`else
  assign rpt_mode_s = 1'b0;
  assign ctrl_rd_s  = 16'h0000;
`endif

  // Next-state, register-file and stream-output computation.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    seed_s      = seed_r;
    pkt_seed_s  = pkt_seed_r;
    beat_s      = beat_r;
    last_s      = last_r;
    pkt_empty_s = pkt_empty_r;
    count_s     = count_r;
    err_s       = err_r;
    stop_s      = stop_r;
    valid_s     = valid_r;
    sop_s       = sop_r;
    eop_s       = eop_r;
    data_s      = data_r;
    empty_s     = empty_r;
    load_s      = 1'b0;
    load_seed_s = seed_r;
`ifdef DIRCC_ST_GEN_REPEAT_EN
    rpt_s       = rpt_r;
`endif

    case (state_r)
      IDLE: begin
        if (start_wr_s) begin
          if (len_r == 16'd0) begin
            err_s = 1'b1;
          end else begin
            load_s = 1'b1;
`ifdef DIRCC_ST_GEN_REPEAT_EN
            rpt_s  = bus.ctrl_writedata[2];
`endif
          end
        end else begin
          load_s = 1'b0;
        end
      end
      SEND: begin
        if (stop_wr_s) begin
          stop_s = 1'b1;
        end else begin
          stop_s = stop_r;
        end
        if (valid_r && bus.src_ready) begin
          if (eop_r) begin
            count_s = count_r + CNT_ONE;
            if (rpt_mode_s && !stop_r && !stop_wr_s && (len_r != 16'd0)) begin
              // Restart with no idle gap; the next packet uses the next seed.
              load_s      = 1'b1;
              load_seed_s = pkt_seed_r + 16'd1;
              seed_s      = load_seed_s;
            end else begin
              // A repeat restart that finds LEN == 0 is flagged like a bad start.
              err_s   = err_r | (rpt_mode_s & ~stop_r & ~stop_wr_s);
              state_s = IDLE;
              valid_s = 1'b0;
              sop_s   = 1'b0;
              eop_s   = 1'b0;
            end
          end else begin
            beat_s  = beat_r + 16'd1;
            data_s  = {pkt_seed_r, beat_r + 16'd1};
            sop_s   = 1'b0;
            eop_s   = ((beat_r + 16'd1) == last_r);
            empty_s = eop_s ? pkt_empty_r : 2'd0;
          end
        end else begin
          beat_s = beat_r;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase

    // Host register writes land after the hardware seed update so they win.
    if (wr_s) begin
      case (bus.ctrl_address)
        2'd1:    len_s  = bus.ctrl_writedata;
        2'd2:    seed_s = bus.ctrl_writedata;
        default: len_s  = len_s;
      endcase
    end else begin
      len_s = len_s;
    end

    // LEN and SEED are sampled here, so later writes only affect the next packet.
    if (load_s) begin
      state_s     = SEND;
      pkt_seed_s  = load_seed_s;
      beat_s      = 16'd0;
      last_s      = last_idx(len_r);
      pkt_empty_s = tail_empty(len_r);
      stop_s      = 1'b0;
      valid_s     = 1'b1;
      sop_s       = 1'b1;
      eop_s       = (last_idx(len_r) == 16'd0);
      data_s      = {load_seed_s, 16'd0};
      empty_s     = eop_s ? tail_empty(len_r) : 2'd0;
    end else begin
      state_s = state_s;
    end

    // Clearing STATUS overrides a completion in the same cycle.
    if (status_wr_s) begin
      count_s = '0;
      err_s   = 1'b0;
    end else begin
      count_s = count_s;
    end
  end

  // State, register file and registered stream outputs.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_r     <= IDLE;
      len_r       <= 16'(DEFAULT_LEN);
      seed_r      <= 16'd0;
      pkt_seed_r  <= 16'd0;
      beat_r      <= 16'd0;
      last_r      <= 16'd0;
      pkt_empty_r <= 2'd0;
      count_r     <= '0;
      err_r       <= 1'b0;
      stop_r      <= 1'b0;
      valid_r     <= 1'b0;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      data_r      <= 32'd0;
      empty_r     <= 2'd0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      seed_r      <= seed_s;
      pkt_seed_r  <= pkt_seed_s;
      beat_r      <= beat_s;
      last_r      <= last_s;
      pkt_empty_r <= pkt_empty_s;
      count_r     <= count_s;
      err_r       <= err_s;
      stop_r      <= stop_s;
      valid_r     <= valid_s;
      sop_r       <= sop_s;
      eop_r       <= eop_s;
      data_r      <= data_s;
      empty_r     <= empty_s;
    end
  end

  // Zero-latency register read mux; idles at 0 when no read is strobed.
  always_comb begin
    rdata_s = 16'h0000;
    if (!bus.ctrl_read_n) begin
      case (bus.ctrl_address)
        2'd0:    rdata_s = ctrl_rd_s;
        2'd1:    rdata_s = len_r;
        2'd2:    rdata_s = seed_r;
        2'd3:    rdata_s = {count_ext_s[13:0], err_r, (state_r != IDLE)};
        default: rdata_s = 16'h0000;
      endcase
    end else begin
      rdata_s = 16'h0000;
    end
  end

  assign bus.ctrl_readdata     = rdata_s;
  assign bus.src_valid         = valid_r;
  assign bus.src_startofpacket = sop_r;
  assign bus.src_endofpacket   = eop_r;
  assign bus.src_data          = data_r;
  assign bus.src_empty         = empty_r;

endmodule

// File: tb/tb_dircc_avalon_st_generator.sv
// Self-checking bench for dircc_avalon_st_generator. Expected packets are built
// from LEN/SEED arithmetic (beat list per packet); inputs change on the falling
// edge and outputs are observed there as well. Repeat-mode checks are compiled
// when DIRCC_ST_GEN_REPEAT_EN is defined.
module tb_dircc_avalon_st_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   model_count = 0;

  dircc_avalon_st_generator_if bus ();

  dircc_avalon_st_generator #(.DEFAULT_LEN(64), .COUNT_W(16)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Expected STATUS value for a given packet count and error flag when idle.
  function automatic logic [15:0] status_of(input int cnt, input bit err, input bit busy);
    logic [31:0] c;
    c = 32'(cnt);
    return {c[13:0], err, busy};
  endfunction

  task automatic mm_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.ctrl_address   = a;
    bus.ctrl_writedata = d;
    bus.ctrl_write_n   = 1'b0;
    @(negedge clk);
    bus.ctrl_write_n   = 1'b1;
  endtask

  task automatic mm_read(input logic [1:0] a, output logic [15:0] d);
    bus.ctrl_address = a;
    bus.ctrl_read_n  = 1'b0;
    #1;
    d = bus.ctrl_readdata;
    bus.ctrl_read_n  = 1'b1;
  endtask

  // Drives src_ready (mode 0 = always, 1 = toggling from 0, 2 = random) and
  // checks npk packets of len bytes with seeds seed, seed+1, ... Optionally
  // writes stop on the cycle the last expected sop is accepted.
  task automatic collect(input int len, input logic [15:0] seed, input int npk,
                         input int mode, input bit send_stop, input string tag);
    logic [35:0] expq[$];
    logic [35:0] obs;
    logic [35:0] prev_obs;
    int beats;
    int cyc;
    int sops;
    bit hold;
    bit tog;
    beats = (len + 3) / 4;
    cyc = 0; sops = 0; hold = 1'b0; tog = 1'b0; prev_obs = '0;
    for (int p = 0; p < npk; p++) begin
      for (int k = 0; k < beats; k++) begin
        expq.push_back({seed + 16'(p), 16'(k), (k == 0), (k == beats - 1),
                        (k == beats - 1) ? 2'((4 - len % 4) % 4) : 2'd0});
      end
    end
    checks++;
    if (bus.src_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: valid=%b required 1", tag, bus.src_valid);
    end
    while (expq.size() > 0 && cyc < 4000) begin
      case (mode)
        0:       bus.src_ready = 1'b1;
        1:       begin bus.src_ready = tog; tog = ~tog; end
        default: bus.src_ready = 1'($urandom_range(0, 1));
      endcase
      obs = {bus.src_data, bus.src_startofpacket, bus.src_endofpacket, bus.src_empty};
      checks++;
      if (bus.src_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid_gap: valid=%b required 1 (%0d beats left)", tag, bus.src_valid, expq.size());
        break;
      end
      if (hold) begin
        checks++;
        if (obs !== prev_obs) begin
          errors++;
          $display("FAIL %s_hold: got %h required %h", tag, obs, prev_obs);
        end
      end
      if (bus.src_ready) begin
        checks++;
        if (obs !== expq[0]) begin
          errors++;
          $display("FAIL %s_beat: got %h required %h", tag, obs, expq[0]);
        end
        if (send_stop && bus.src_startofpacket) begin
          sops++;
          if (sops == npk) begin
            bus.ctrl_address   = 2'd0;
            bus.ctrl_writedata = 16'h0002;
            bus.ctrl_write_n   = 1'b0;
          end
        end
        void'(expq.pop_front());
      end
      hold = !bus.src_ready;
      prev_obs = obs;
      @(negedge clk);
      bus.ctrl_write_n = 1'b1;
      cyc++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_incomplete: %0d beats missing, required 0", tag, expq.size());
    end
    checks++;
    if (bus.src_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_eop: valid=%b required 0", tag, bus.src_valid);
    end
    bus.src_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data, bus.src_empty} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid/sop/eop/data/empty=%h required 0",
               {bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data, bus.src_empty});
    end
    rst = 1'b0;
    @(negedge clk);
    mm_read(2'd1, d);
    checks++;
    if (d !== 16'd64) begin errors++; $display("FAIL reset_len: got %h required 0040", d); end
    mm_read(2'd3, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h required 0000", d); end
    mm_read(2'd2, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_seed: got %h required 0000", d); end
    checks++;
    if (bus.ctrl_readdata !== 16'h0000) begin
      errors++; $display("FAIL readdata_idle: got %h required 0000", bus.ctrl_readdata);
    end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    mm_write(2'd3, 16'h0000);
    model_count = 0;
    mm_write(2'd1, 16'd10);
    mm_write(2'd2, 16'hABCD);
    mm_write(2'd0, 16'h0001);
    collect(10, 16'hABCD, 1, 0, 1'b0, "basic");
    model_count++;
    mm_read(2'd3, d);
    checks++;
    if (d !== status_of(model_count, 1'b0, 1'b0)) begin
      errors++; $display("FAIL basic_status: got %h required %h", d, status_of(model_count, 1'b0, 1'b0));
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    mm_write(2'd3, 16'h0000);
    model_count = 0;
    mm_write(2'd1, 16'd4);
    mm_write(2'd2, 16'h1234);
    mm_write(2'd0, 16'h0001);
    mm_read(2'd3, d);
    checks++;
    if (d !== status_of(0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL bp_busy: got %h required 0001", d);
    end
    collect(4, 16'h1234, 1, 1, 1'b0, "bp");
    model_count++;
    mm_read(2'd3, d);
    checks++;
    if (d !== status_of(model_count, 1'b0, 1'b0)) begin
      errors++; $display("FAIL bp_status: got %h required %h", d, status_of(model_count, 1'b0, 1'b0));
    end
  endtask

  task automatic test_len_zero();
    logic [15:0] d;
    bit seen;
    mm_write(2'd3, 16'h0000);
    model_count = 0;
    mm_write(2'd1, 16'd0);
    mm_write(2'd0, 16'h0001);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.src_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL len0_valid: valid seen=1 required 0"); end
    mm_read(2'd3, d);
    checks++;
    if (d !== status_of(0, 1'b1, 1'b0)) begin errors++; $display("FAIL len0_err: got %h required 0002", d); end
    mm_write(2'd3, 16'hFFFF);
    mm_read(2'd3, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL len0_clear: got %h required 0000", d); end
  endtask

  task automatic test_start_stop();
    logic [15:0] d;
    bit seen;
    mm_write(2'd1, 16'd8);
    mm_write(2'd0, 16'h0003);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.src_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL startstop_valid: valid seen=1 required 0"); end
    mm_read(2'd3, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL startstop_status: got %h required 0000", d); end
  endtask

  task automatic test_latch_and_busy_start();
    logic [15:0] d;
    mm_write(2'd3, 16'h0000);
    model_count = 0;
    bus.src_ready = 1'b0;
    mm_write(2'd1, 16'd12);
    mm_write(2'd2, 16'h1111);
    mm_write(2'd0, 16'h0001);
    mm_write(2'd1, 16'd5);
    mm_write(2'd2, 16'h2222);
    mm_write(2'd0, 16'h0001);
    collect(12, 16'h1111, 1, 2, 1'b0, "latch_a");
    model_count++;
    mm_write(2'd0, 16'h0001);
    collect(5, 16'h2222, 1, 2, 1'b0, "latch_b");
    model_count++;
    mm_read(2'd3, d);
    checks++;
    if (d !== status_of(model_count, 1'b0, 1'b0)) begin
      errors++; $display("FAIL latch_status: got %h required %h", d, status_of(model_count, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] seed;
    int len;
    for (int it = 0; it < 5; it++) begin
      len  = $urandom_range(1, 48);
      seed = 16'($urandom);
      mm_write(2'd1, 16'(len));
      mm_write(2'd2, seed);
      mm_write(2'd0, 16'h0001);
      collect(len, seed, 1, 2, 1'b0, "rand");
      model_count++;
      mm_read(2'd3, d);
      checks++;
      if (d !== status_of(model_count, 1'b0, 1'b0)) begin
        errors++; $display("FAIL rand_status: len=%0d got %h required %h", len, d, status_of(model_count, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic [15:0] d;
    mm_write(2'd3, 16'h0000);
    model_count = 0;
    mm_write(2'd1, 16'd40);
    mm_write(2'd2, 16'h5A5A);
    mm_write(2'd0, 16'h0001);
    bus.src_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.src_valid, bus.src_data} !== {1'b1, 32'h5A5A0002}) begin
      errors++; $display("FAIL mid_progress: got %h required 15a5a0002", {bus.src_valid, bus.src_data});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data} !== 35'd0) begin
      errors++; $display("FAIL mid_async_drop: got %h required 0",
                         {bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data});
    end
    bus.src_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mm_read(2'd3, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL mid_count: got %h required 0000", d); end
  endtask

`ifdef DIRCC_ST_GEN_REPEAT_EN
  task automatic test_repeat();
    logic [15:0] d;
    mm_write(2'd3, 16'h0000);
    model_count = 0;
    mm_write(2'd1, 16'd8);
    mm_write(2'd2, 16'h0000);
    mm_write(2'd0, 16'h0005);
    mm_read(2'd0, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL rpt_ctrl_read: got %h required 0004", d); end
    collect(8, 16'h0000, 3, 0, 1'b1, "repeat");
    model_count = 3;
    mm_read(2'd3, d);
    checks++;
    if (d !== status_of(model_count, 1'b0, 1'b0)) begin
      errors++; $display("FAIL rpt_status: got %h required %h", d, status_of(model_count, 1'b0, 1'b0));
    end
  endtask
`else
  task automatic test_no_repeat();
    logic [15:0] d;
    mm_write(2'd1, 16'd8);
    mm_write(2'd2, 16'h0007);
    mm_write(2'd0, 16'h0005);
    mm_read(2'd0, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL norpt_ctrl_read: got %h required 0000", d); end
    collect(8, 16'h0007, 1, 0, 1'b0, "norpt");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.src_valid !== 1'b0) begin errors++; $display("FAIL norpt_single: valid=%b required 0", bus.src_valid); end
    mm_read(2'd2, d);
    checks++;
    if (d !== 16'h0007) begin errors++; $display("FAIL norpt_seed: got %h required 0007", d); end
  endtask
`endif

  initial begin
    bus.src_ready      = 1'b0;
    bus.ctrl_address   = 2'd0;
    bus.ctrl_read_n    = 1'b1;
    bus.ctrl_write_n   = 1'b1;
    bus.ctrl_writedata = 16'h0000;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_start_stop();
    test_latch_and_busy_start();
    test_random();
    test_reset_midpacket();
`ifdef DIRCC_ST_GEN_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
